// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared types and constants for the banked memory block.
//   state_e  - sweep FSM states (CLEAR runs the initialisation sweep, IDLE serves accesses)
//   ERR_W    - width of the out-of-range access counter
//   ERR_MAX  - saturation value of that counter
package banked_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

endpackage

// File: rtl/banked_mem_if.sv
// banked_mem_if: access bus of banked_mem.
//   master modport - requester side (drives clr, write and read requests)
//   slave modport  - memory side (returns busy, read response, oob flags, err_cnt)
// Signals:
//   clr, busy                              - sweep control/status
//   wr_en, wr_bank, wr_addr, wr_data       - write request
//   rd_en, rd_bank, rd_addr                - read request
//   rd_valid, rd_data, rd_oob              - registered read response
//   wr_oob                                 - out-of-range write pulse
//   err_cnt                                - saturating out-of-range count
interface banked_mem_if #(
  parameter int WIDTH = 8,
  parameter int BA_W  = 3,
  parameter int AA_W  = 3
);
  import banked_mem_pkg::*;

  logic             clr;
  logic             busy;
  logic             wr_en;
  logic [BA_W-1:0]  wr_bank;
  logic [AA_W-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [BA_W-1:0]  rd_bank;
  logic [AA_W-1:0]  rd_addr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_oob;
  logic             wr_oob;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output clr, wr_en, wr_bank, wr_addr, wr_data, rd_en, rd_bank, rd_addr,
    input  busy, rd_valid, rd_data, rd_oob, wr_oob, err_cnt
  );

  modport slave (
    input  clr, wr_en, wr_bank, wr_addr, wr_data, rd_en, rd_bank, rd_addr,
    output busy, rd_valid, rd_data, rd_oob, wr_oob, err_cnt
  );

endinterface

// File: rtl/banked_mem_sweep.sv
// banked_mem_sweep: clear-sweep FSM and word counter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - restart the sweep (from IDLE or mid-sweep)
//   busy        - high while the sweep runs (state == CLEAR)
//   sweep_we    - write INIT into word sweep_idx of every bank this cycle
//   sweep_idx   - word currently being cleared
// A sweep lasts exactly DEPTH cycles; reset leaves the FSM in CLEAR at word 0.
module banked_mem_sweep
  import banked_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          busy,
  output logic          sweep_we,
  output logic [IW-1:0] sweep_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          // clr mid-sweep takes priority over finishing the sweep
          if (clr) begin
            idx_q <= '0;
          end else if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sweep_we  = busy_q;
  assign sweep_idx = idx_q;

endmodule

// File: rtl/banked_mem.sv
// banked_mem: BANKS x DEPTH register-file memory of WIDTH-bit words with one
// write port, one registered read port (latency 1, read-before-write),
// bounds checking on every access and a hardware clear sweep.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - banked_mem_if slave modport (requests in, response/status out)
// Out-of-range accesses never touch storage; they raise rd_oob / wr_oob and
// bump the saturating err_cnt. Accesses are ignored while busy.
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               BANKS = 2,
  parameter int               DEPTH = 4,
  parameter int               BA_W  = 3,
  parameter int               AA_W  = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic         clk,
  input  logic         reset,
  banked_mem_if.slave  bus
);

  // Internal index widths sized to the array; only used once the full-width
  // request has been proven in range, so the truncation cannot alias.
  localparam int BI_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int AI_W = $clog2(DEPTH);

  function automatic logic in_range(input logic [BA_W-1:0] bank,
                                    input logic [AA_W-1:0] addr);
    return (32'(bank) < BANKS) && (32'(addr) < DEPTH);
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W - 1){1'b0}}, inc};
    return (32'(sum) > ERR_MAX) ? ERR_W'(ERR_MAX) : sum[ERR_W-1:0];
  endfunction

  logic             busy;
  logic             sweep_we;
  logic [AI_W-1:0]  sweep_idx;

  logic [WIDTH-1:0] mem_q [0:BANKS-1][0:DEPTH-1];
  logic [WIDTH-1:0] mem_d [0:BANKS-1][0:DEPTH-1];

  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q,  rd_data_d;
  logic             rd_oob_q,   rd_oob_d;
  logic             wr_oob_q,   wr_oob_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

  logic             wr_acc, rd_acc, wr_hit, rd_hit;
  logic [BI_W-1:0]  wb, rb;
  logic [AI_W-1:0]  wa, ra;
  logic [1:0]       err_inc;

  banked_mem_sweep #(
    .DEPTH (DEPTH),
    .IW    (AI_W)
  ) u_sweep (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.clr),
    .busy      (busy),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  always_comb begin
    wr_acc  = bus.wr_en && !busy;
    rd_acc  = bus.rd_en && !busy;
    wr_hit  = in_range(bus.wr_bank, bus.wr_addr);
    rd_hit  = in_range(bus.rd_bank, bus.rd_addr);
    wb      = bus.wr_bank[BI_W-1:0];
    wa      = bus.wr_addr[AI_W-1:0];
    rb      = bus.rd_bank[BI_W-1:0];
    ra      = bus.rd_addr[AI_W-1:0];
    err_inc = {1'b0, wr_acc && !wr_hit} + {1'b0, rd_acc && !rd_hit};

    mem_d = mem_q;
    if (sweep_we) begin
      for (int b = 0; b < BANKS; b++) begin
        mem_d[b][sweep_idx] = INIT;
      end
    end else if (wr_acc && wr_hit) begin
      mem_d[wb][wa] = bus.wr_data;
    end

    // Read samples mem_q, so a same-cycle write to the same word is not seen.
    rd_valid_d = rd_acc;
    rd_oob_d   = rd_acc && !rd_hit;
    rd_data_d  = rd_data_q;
    if (rd_acc) begin
      rd_data_d = rd_hit ? mem_q[rb][ra] : '0;
    end

    wr_oob_d  = wr_acc && !wr_hit;
    err_cnt_d = bus.clr ? '0 : sat_add(err_cnt_q, err_inc);
  end

  // storage: no reset, the sweep initialises it
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // read response and error status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_oob_q   <= 1'b0;
      wr_oob_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_oob_q   <= rd_oob_d;
      wr_oob_q   <= wr_oob_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_oob   = rd_oob_q;
  assign bus.wr_oob   = wr_oob_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_banked_mem.sv
// tb_banked_mem: directed self-checking bench for banked_mem (default
// parameters: 2 banks x 4 words x 8 bits, 3-bit bank/address ports).
module tb_banked_mem;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  banked_mem_if #(.WIDTH(8), .BA_W(3), .AA_W(3)) bus ();

  banked_mem #(
    .WIDTH (8),
    .BANKS (2),
    .DEPTH (4),
    .BA_W  (3),
    .AA_W  (3),
    .INIT  (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] b, input logic [2:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_bank = b;
    bus.wr_addr = a;
    bus.wr_data = d;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] b, input logic [2:0] a,
                         output logic [7:0] d, output logic v, output logic o);
    bus.rd_en   = 1'b1;
    bus.rd_bank = b;
    bus.rd_addr = a;
    cyc();
    d = bus.rd_data;
    v = bus.rd_valid;
    o = bus.rd_oob;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] d;
    logic v, o;
    reset = 1'b1;
    repeat (2) cyc();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0h exp=1", bus.busy); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0h exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%0h exp=00", bus.rd_data); end
    checks++; if (bus.rd_oob !== 1'b0) begin failures++; $display("FAIL reset_rd_oob got=%0h exp=0", bus.rd_oob); end
    checks++; if (bus.wr_oob !== 1'b0) begin failures++; $display("FAIL reset_wr_oob got=%0h exp=0", bus.wr_oob); end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", bus.err_cnt); end
    reset = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      cyc();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL reset_busy_len got=%0d exp=4", n); end
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) begin
        do_read(3'(b), 3'(a), d, v, o);
        checks++; if (v !== 1'b1 || d !== 8'h00 || o !== 1'b0) begin
          failures++; $display("FAIL init_read[%0d][%0d] got=v%0h d%0h o%0h exp=v1 d00 o0", b, a, v, d, o);
        end
      end
    end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL init_err_cnt got=%0d exp=0", bus.err_cnt); end
  endtask

  task automatic test_write_read();
    logic [7:0] d, e;
    logic v, o;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) begin
        do_write(3'(b), 3'(a), 8'hf0 + 8'(b * 4 + a));
        checks++; if (bus.wr_oob !== 1'b0) begin failures++; $display("FAIL wr_inrange_oob[%0d][%0d] got=%0h exp=0", b, a, bus.wr_oob); end
      end
    end
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) begin
        e = 8'hf0 + 8'(b * 4 + a);
        do_read(3'(b), 3'(a), d, v, o);
        checks++; if (v !== 1'b1 || d !== e || o !== 1'b0) begin
          failures++; $display("FAIL readback[%0d][%0d] got=v%0h d%0h o%0h exp=v1 d%0h o0", b, a, v, d, o, e);
        end
        cyc();
        checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_pulse[%0d][%0d] got=%0h exp=0", b, a, bus.rd_valid); end
        checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL rd_data_hold[%0d][%0d] got=%0h exp=%0h", b, a, bus.rd_data, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.rd_en   = 1'b1;
    bus.rd_bank = 3'd0;
    bus.rd_addr = 3'd0;
    cyc();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hf0) begin
      failures++; $display("FAIL b2b_first got=v%0h d%0h exp=v1 df0", bus.rd_valid, bus.rd_data);
    end
    bus.rd_bank = 3'd1;
    bus.rd_addr = 3'd3;
    cyc();
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hf7) begin
      failures++; $display("FAIL b2b_second got=v%0h d%0h exp=v1 df7", bus.rd_valid, bus.rd_data);
    end
    bus.rd_en = 1'b0;
    cyc();
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0h exp=0", bus.rd_valid); end
  endtask

  task automatic test_oob();
    int pulses;
    logic [7:0] d;
    logic v, o;
    logic [2:0] wb [3];
    logic [2:0] wa [3];
    logic [7:0] wd [3];
    wb = '{3'd3, 3'd3, 3'd4};
    wa = '{3'd0, 3'd1, 3'd2};
    wd = '{8'hc1, 8'hc2, 8'hc3};
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      do_write(wb[i], wa[i], wd[i]);
      if (bus.wr_oob === 1'b1) pulses++;
      cyc();
      if (bus.wr_oob === 1'b1) pulses++;
    end
    checks++; if (pulses != 3) begin failures++; $display("FAIL wr_oob_pulses got=%0d exp=3", pulses); end
    checks++; if (bus.err_cnt !== 8'd3) begin failures++; $display("FAIL oob_err_cnt3 got=%0d exp=3", bus.err_cnt); end
    for (int a = 0; a < 4; a++) begin
      do_read(3'd1, 3'(a), d, v, o);
      checks++; if (v !== 1'b1 || d !== 8'hf4 + 8'(a) || o !== 1'b0) begin
        failures++; $display("FAIL oob_reread[1][%0d] got=v%0h d%0h o%0h exp=v1 d%0h o0", a, v, d, o, 8'hf4 + 8'(a));
      end
    end
    do_read(3'd3, 3'd0, d, v, o);
    checks++; if (v !== 1'b1 || d !== 8'h00 || o !== 1'b1) begin
      failures++; $display("FAIL oob_read_bank got=v%0h d%0h o%0h exp=v1 d00 o1", v, d, o);
    end
    checks++; if (bus.err_cnt !== 8'd4) begin failures++; $display("FAIL oob_err_cnt4 got=%0d exp=4", bus.err_cnt); end
    do_read(3'd0, 3'd4, d, v, o);
    checks++; if (v !== 1'b1 || d !== 8'h00 || o !== 1'b1) begin
      failures++; $display("FAIL oob_read_addr got=v%0h d%0h o%0h exp=v1 d00 o1", v, d, o);
    end
    do_write(3'd1, 3'd4, 8'hc9);
    checks++; if (bus.wr_oob !== 1'b1) begin failures++; $display("FAIL oob_write_addr got=%0h exp=1", bus.wr_oob); end
    checks++; if (bus.err_cnt !== 8'd6) begin failures++; $display("FAIL oob_err_cnt6 got=%0d exp=6", bus.err_cnt); end
    do_read(3'd1, 3'd0, d, v, o);
    checks++; if (d !== 8'hf4 || o !== 1'b0) begin failures++; $display("FAIL oob_no_alias got=d%0h o%0h exp=df4 o0", d, o); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] d;
    logic v, o;
    bus.wr_en   = 1'b1;
    bus.wr_bank = 3'd0;
    bus.wr_addr = 3'd2;
    bus.wr_data = 8'h55;
    bus.rd_en   = 1'b1;
    bus.rd_bank = 3'd0;
    bus.rd_addr = 3'd2;
    cyc();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hf2) begin
      failures++; $display("FAIL rbw_old got=v%0h d%0h exp=v1 df2", bus.rd_valid, bus.rd_data);
    end
    do_read(3'd0, 3'd2, d, v, o);
    checks++; if (v !== 1'b1 || d !== 8'h55) begin failures++; $display("FAIL rbw_new got=v%0h d%0h exp=v1 d55", v, d); end
    checks++; if (bus.err_cnt !== 8'd6) begin failures++; $display("FAIL rbw_err_cnt got=%0d exp=6", bus.err_cnt); end
  endtask

  task automatic test_saturate_clr();
    int n;
    logic [7:0] d;
    logic v, o;
    bus.wr_en   = 1'b1;
    bus.wr_bank = 3'd7;
    bus.wr_addr = 3'd7;
    bus.wr_data = 8'haa;
    bus.rd_en   = 1'b1;
    bus.rd_bank = 3'd7;
    bus.rd_addr = 3'd7;
    cyc();
    checks++; if (bus.err_cnt !== 8'd8) begin failures++; $display("FAIL dual_oob_err got=%0d exp=8", bus.err_cnt); end
    checks++; if (bus.rd_oob !== 1'b1 || bus.wr_oob !== 1'b1) begin
      failures++; $display("FAIL dual_oob_flags got=r%0h w%0h exp=r1 w1", bus.rd_oob, bus.wr_oob);
    end
    repeat (199) cyc();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++; if (bus.err_cnt !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d exp=255", bus.err_cnt); end
    cyc();
    checks++; if (bus.err_cnt !== 8'd255) begin failures++; $display("FAIL err_hold got=%0d exp=255", bus.err_cnt); end
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL clr_err_cnt got=%0d exp=0", bus.err_cnt); end
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      cyc();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL clr_busy_len got=%0d exp=4", n); end
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 4; a++) begin
        do_read(3'(b), 3'(a), d, v, o);
        checks++; if (v !== 1'b1 || d !== 8'h00 || o !== 1'b0) begin
          failures++; $display("FAIL clr_read[%0d][%0d] got=v%0h d%0h o%0h exp=v1 d00 o0", b, a, v, d, o);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [7:0] d;
    logic v, o;
    do_write(3'd1, 3'd1, 8'h3c);
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    cyc();
    cyc();
    bus.rd_en   = 1'b1;
    bus.rd_bank = 3'd0;
    bus.rd_addr = 3'd0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_reset_busy got=%0h exp=1", bus.busy); end
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_rd_valid[%0d] got=%0h exp=0", n, bus.rd_valid); end
      n++;
      cyc();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL mid_reset_busy_len got=%0d exp=4", n); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL busy_rd_ignored got=%0h exp=0", bus.rd_valid); end
    bus.rd_en = 1'b0;
    do_read(3'd1, 3'd1, d, v, o);
    checks++; if (v !== 1'b1 || d !== 8'h00 || o !== 1'b0) begin
      failures++; $display("FAIL mid_reset_read got=v%0h d%0h o%0h exp=v1 d00 o0", v, d, o);
    end
    checks++; if (bus.err_cnt !== 8'd0) begin failures++; $display("FAIL mid_reset_err got=%0d exp=0", bus.err_cnt); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_bank = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_bank = '0;
    bus.rd_addr = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_oob();
    test_same_cycle();
    test_saturate_clr();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_mem.md
# banked_mem

Parametrised banked register-file memory: BANKS banks of DEPTH words of WIDTH bits, one write port, one registered read port, per-access bounds checking and a hardware clear sweep. It is the general storage primitive for testbench prototypes and small RTL buffers that need a 2-D array. Out-of-range bank or address indices are detected, suppressed and counted instead of silently aliasing or being dropped.

## Interface
- WIDTH, 8, data bits per word
- BANKS, 2, number of banks (≥1, need not be a power of two)
- DEPTH, 4, words per bank (≥2, need not be a power of two)
- BA_W, 3, bank-index port width; must be ≥ $clog2(BANKS)
- AA_W, 3, address port width; must be ≥ $clog2(DEPTH)
- INIT, 0, value written to every word by the clear sweep
- clk  in  1  sole clock; all logic on its rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- clr  in  1  one-cycle request to re-run the clear sweep and zero err_cnt
- busy  out  1  high while the clear sweep runs
- wr_en  in  1  write request
- wr_bank  in  BA_W  write bank index
- wr_addr  in  AA_W  write word index
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_bank  in  BA_W  read bank index
- rd_addr  in  AA_W  read word index
- rd_valid  out  1  rd_data/rd_oob valid this cycle
- rd_data  out  WIDTH  read data
- rd_oob  out  1  the completed read was out of range
- wr_oob  out  1  the previous cycle's write was out of range
- err_cnt  out  8  saturating count of out-of-range accesses

## Operation
- FSM states: CLEAR, IDLE. busy = (state == CLEAR).
- CLEAR: sweep counter idx writes INIT to word idx of every bank in one cycle. When idx == DEPTH-1, go to IDLE and reset idx to 0. A sweep takes exactly DEPTH cycles.
- IDLE: clr moves the FSM to CLEAR with idx=0 and sets err_cnt=0. In CLEAR, clr restarts the sweep at idx 0.
- A write is in range when wr_bank < BANKS and wr_addr < DEPTH.
  - In range: the word is updated at the clock edge.
  - Out of range: no storage changes, wr_oob pulses next cycle, err_cnt += 1.
- A read is in range by the same rule.
  - In range: rd_data = stored word.
  - Out of range: rd_data = 0, rd_oob = 1, err_cnt += 1.
- Read and write to the same word in the same cycle: read returns the old data (read-before-write).
- If a read and a write are both out of range in the same cycle, err_cnt increases by 2. err_cnt saturates at 255.
- While busy, wr_en and rd_en are ignored: no storage update, no rd_valid, no oob flags, no count. Requesters must gate on busy.

## Timing
- When reset is high at an edge:
  - state=CLEAR, idx=0
  - busy=1
  - rd_valid=0, rd_data=0, rd_oob=0, wr_oob=0
  - err_cnt=0
  - storage contents are don't-care until the sweep overwrites them
- After reset deasserts, busy stays high for DEPTH cycles, then drops. The first access is accepted in the cycle busy is low.
- Read latency is 1: rd_en sampled at edge N gives rd_valid=1 with rd_data and rd_oob after edge N. rd_valid is a single-cycle pulse per request, and back-to-back reads give back-to-back valids.
- rd_data holds its last value when rd_valid=0. It is zeroed only by reset.
- wr_oob is a 1-cycle pulse registered from the write attempt.
- Reset asserted mid-sweep or mid-read: all registers go to their reset values and the sweep restarts from idx 0. No pending rd_valid survives.
- clr in the same cycle as an IDLE access: the access is processed normally and the sweep begins next cycle.

## Structure
- Package banked_mem_pkg holds:
  - state enum {CLEAR, IDLE}
  - ERR_W = 8
  - ERR_MAX = 255
- Sub-module banked_mem_sweep contains the FSM and idx counter. Its outputs are busy, sweep_we and sweep_idx. The top level contains storage, bounds checks, the read register and err_cnt.
- Storage is a 2-D unpacked array [0:BANKS-1][0:DEPTH-1] of WIDTH-bit words. Index comparisons use full BA_W/AA_W widths with no truncation.

## Test plan
All scenarios use default parameters unless stated.
- Reset release: busy high for exactly 4 cycles. Then reading all 8 words returns 8'h00, and rd_oob and err_cnt stay 0.
- Write 8'hf0..8'hf7 to [0][0..3] and [1][0..3], then read them all back. Each read returns its value one cycle after rd_en, with rd_valid=1 for exactly one cycle.
- Write 8'hc1 to [3][0], 8'hc2 to [3][1] and 8'hc3 to [4][2]:
  - wr_oob pulses 3 times and err_cnt=3
  - rereading [1][0..3] still returns f4..f7
  - reading [3][0] returns 8'h00 with rd_oob=1 and err_cnt=4
- Same cycle: write 8'h55 to [0][2] and read [0][2] (holding 8'hf2). rd_data is 8'hf2; a read on the next cycle returns 8'h55.
- Out-of-range read and write in the same cycle give err_cnt += 2. Repeating 200 times saturates err_cnt at 255. A following clr zeros err_cnt, busy is high 4 cycles, and every word then reads 8'h00.
- Assert reset for 1 cycle at idx=2 of a clr-started sweep. busy is high 4 more cycles, rd_valid stays 0 throughout, and a rd_en issued while busy produces no rd_valid.
